// File: rtl/umich_mult_seq_op.sv
// Iterative radix-2 shift-add multiplier producing the full 2*WIDTH-bit product.
// Latency: WIDTH+1 cycles from accept to out_valid; issue interval WIDTH+2 cycles.
// Backpressure: DONE holds Z/out_valid while out_ready=0; in_ready=0 until IDLE.
//
// Ports:
//   clocked_on          rising-edge clock
//   clear_n             asynchronous active-low reset
//   A, B [WIDTH]        multiplicand / multiplier, sampled on accept
//   tc                  1 = two's-complement operands (only with UMICH_MULT_SEQ_TC_EN)
//   in_valid/in_ready   operand handshake
//   Z [2*WIDTH]         product, changes only on the edge entering DONE
//   out_valid/out_ready result handshake
//
// Build option: define UMICH_MULT_SEQ_TC_EN to compile in signed support;
// without it tc is ignored and every operation is unsigned.

module umich_mult_seq_op #(
   parameter int WIDTH = 64
) (
   input  logic                 clocked_on,
   input  logic                 clear_n,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic                 tc,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [2*WIDTH-1:0]   Z,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [2*WIDTH-1:0]   r_acc;
   logic [CW-1:0]        r_cnt;
   logic [2*WIDTH-1:0]   r_z;
   logic                 r_in_ready;
   logic                 r_out_valid;

   logic [WIDTH-1:0]     w_mag_a;
   logic [WIDTH-1:0]     w_mag_b;
   logic [2*WIDTH-1:0]   w_acc_sum;
   logic [2*WIDTH-1:0]   w_z_next;
   logic                 w_accept;

   assign w_accept  = (r_state == IDLE) & in_valid;
   assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});

`ifdef UMICH_MULT_SEQ_TC_EN
   logic r_neg;

   // Magnitudes stay WIDTH bits unsigned: -2^(W-1) negates to 2^(W-1) exactly.
   assign w_mag_a  = (tc & A[WIDTH-1]) ? (~A + 1'b1) : A;
   assign w_mag_b  = (tc & B[WIDTH-1]) ? (~B + 1'b1) : B;
   assign w_z_next = r_neg ? (~w_acc_sum + 1'b1) : w_acc_sum;

   always_ff @(posedge clocked_on or negedge clear_n) begin
      if (!clear_n) begin
         r_neg <= 1'b0;
      end else if (w_accept) begin
         r_neg <= tc & (A[WIDTH-1] ^ B[WIDTH-1]);
      end
   end
`else
   // tc is kept on the port for drop-in compatibility but has no effect here.
   logic w_unused_tc;
   assign w_unused_tc = tc;
   assign w_mag_a     = A;
   assign w_mag_b     = B;
   assign w_z_next    = w_acc_sum;
`endif

   always_ff @(posedge clocked_on or negedge clear_n) begin
      if (!clear_n) begin
         r_state     <= IDLE;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_z         <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_mcand    <= {{WIDTH{1'b0}}, w_mag_a};
                  r_mplier   <= w_mag_b;
                  r_acc      <= '0;
                  r_cnt      <= CW'(WIDTH);
                  r_state    <= BUSY;
                  r_in_ready <= 1'b0;
               end
            end
            BUSY: begin
               r_acc    <= w_acc_sum;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt - 1'b1;
               // Last iteration: the sum from this step is the final magnitude.
               if (r_cnt == CW'(1)) begin
                  r_z         <= w_z_next;
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign Z         = r_z;

endmodule

// File: tb/tb_umich_mult_seq_op.sv
module tb_umich_mult_seq_op;

   localparam int W = 8;

   logic           clk;
   logic           clear_n;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           tc;
   logic           in_valid;
   logic           in_ready;
   logic [2*W-1:0] z;
   logic           out_valid;
   logic           out_ready;

   int n_checks;
   int n_errors;

   umich_mult_seq_op #(.WIDTH(W)) dut (
      .clocked_on (clk),
      .clear_n    (clear_n),
      .A          (a),
      .B          (b),
      .tc         (tc),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .Z          (z),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation and wait for out_valid; latency counts the accept cycle as 1.
   // With hold_iv set, in_valid stays high with different data while BUSY.
   task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vtc,
                         input logic [2*W-1:0] exp_z, input string tag, input bit hold_iv);
      int lat;
      a        = va;
      b        = vb;
      tc       = vtc;
      in_valid = 1'b1;
      tick();
      if (hold_iv) begin
         a = 8'hAA;
         b = 8'h55;
      end else begin
         in_valid = 1'b0;
      end
      check({tag, "_busy_in_ready"}, {31'd0, in_ready}, 32'd0);
      lat = 1;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, lat, 32'd9);
      check({tag, "_z"}, {16'd0, z}, {16'd0, exp_z});
   endtask

   // Single-cycle consume; IDLE must follow on the next cycle with Z held.
   task automatic release_out(input logic [2*W-1:0] exp_z, input string tag);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_ov_after"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_ir_after"}, {31'd0, in_ready}, 32'd1);
      check({tag, "_z_hold"}, {16'd0, z}, {16'd0, exp_z});
   endtask

   task automatic op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vtc,
                     input logic [2*W-1:0] exp_z, input string tag);
      run_op(va, vb, vtc, exp_z, tag, 1'b0);
      release_out(exp_z, tag);
   endtask

   initial begin
      int stray;
      n_checks  = 0;
      n_errors  = 0;
      clear_n   = 1'b0;
      a         = '0;
      b         = '0;
      tc        = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;

      // Reset state
      repeat (3) tick();
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_z", {16'd0, z}, 32'h0000);
      clear_n = 1'b1;
      tick();

      // Unsigned basics and extremes
      op(8'd3,  8'd5,  1'b0, 16'h000F, "u3x5");
      op(8'hFF, 8'hFF, 1'b0, 16'hFE01, "uFFxFF");
      op(8'h00, 8'hAB, 1'b0, 16'h0000, "u0xAB");
      op(8'hAB, 8'h00, 1'b0, 16'h0000, "uABx0");
      op(8'h12, 8'h34, 1'b0, 16'h03A8, "u12x34");

      // tc=1 vectors: signed results with the option built in, unsigned otherwise
`ifdef UMICH_MULT_SEQ_TC_EN
      op(8'hFD, 8'd5,  1'b1, 16'hFFF1, "sFDx5");
      op(8'h80, 8'h80, 1'b1, 16'h4000, "s80x80");
      op(8'h80, 8'h01, 1'b1, 16'hFF80, "s80x1");
      op(8'd3,  8'hFB, 1'b1, 16'hFFF1, "s3xFB");
      op(8'hFF, 8'hFF, 1'b1, 16'h0001, "sFFxFF");
`else
      op(8'hFD, 8'd5,  1'b1, 16'h04F1, "sFDx5");
      op(8'h80, 8'h80, 1'b1, 16'h4000, "s80x80");
      op(8'h80, 8'h01, 1'b1, 16'h0080, "s80x1");
      op(8'd3,  8'hFB, 1'b1, 16'h02F1, "s3xFB");
      op(8'hFF, 8'hFF, 1'b1, 16'hFE01, "sFFxFF");
`endif
      op(8'd7,  8'd6,  1'b1, 16'h002A, "s7x6");
      // Signed-looking operands with tc=0 must stay unsigned
      op(8'hFD, 8'd5,  1'b0, 16'h04F1, "uFDx5");

      // Backpressure: in_valid held high through BUSY and DONE with other data
      run_op(8'h12, 8'h34, 1'b0, 16'h03A8, "bp", 1'b1);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("bp_ov_hold", {31'd0, out_valid}, 32'd1);
         check("bp_z_hold", {16'd0, z}, 32'h03A8);
         check("bp_ir_low", {31'd0, in_ready}, 32'd0);
      end
      release_out(16'h03A8, "bp");
      repeat (3) tick();
      check("bp_no_accept", {31'd0, in_ready}, 32'd1);

      // Reset mid-operation
      a        = 8'd9;
      b        = 8'd9;
      tc       = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      clear_n = 1'b0;
      #1;
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_z", {16'd0, z}, 32'h0000);
      tick();
      clear_n = 1'b1;
      stray = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (out_valid) stray++;
      end
      check("mid_rst_no_output", stray, 32'd0);
      check("mid_rst_idle", {31'd0, in_ready}, 32'd1);
      op(8'd2, 8'd7, 1'b0, 16'h000E, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
